cofactor_shift_ctrl: RTL
========================

# cofactor_shift_ctrl

Sequencer for the stabilizer row register array and its commutativity/literal stage. On a single start command it performs one of three row-walk operations over all `num_qubit` rows of the rotating register array: external load, cofactor update, or Toffoli phase update. It drives the row-mux select (`mux_shift_in`), the array shift enable and the anticommute-capture clear (`rst_flag`). It consumes the stage's `anticommute` / `flag_anticommute` outputs and reports the cofactor outcome.

## Interface
- `num_qubit`, default 3: number of rows in the array, equal to the number of literals per row; minimum 1.
- `CW`, default `$clog2(num_qubit)` (min 1): row counter width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  2  command, sampled with `start`: 0 = load, 1 = cofactor, 2 = toffoli, 3 = illegal.
- `in_valid`  in  1  external row available on the stage's `literals_in` / `phase_in`.
- `in_ready`  out  1  high in LOAD; a row is taken when `in_valid && in_ready`.
- `anticommute`  in  1  head row has X/Y literal at column 0.
- `flag_anticommute`  in  1  first anticommuting row already captured.
- `mux_shift_in`  out  3  row-mux select: 0 = remain, 1 = basis, 2 = mult, 3 = external, 4 = toffoli.
- `shift_en`  out  1  array rotates by one row this cycle.
- `rst_flag`  out  1  clears the anticommute capture register.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the command is rejected.
- `found`  out  1  the last cofactor found an anticommuting row (random outcome); held until the next cofactor start.
- `first_row`  out  CW  index of the first anticommuting row in the last cofactor; held until the next cofactor start.

## Operation
- States: IDLE, CLEAR, SCAN, UPDATE, LOAD, TOFF, DONE.
- Reset values: IDLE; all outputs 0; `mux_shift_in` = 0; row counter = 0.
- In IDLE, `start` moves the FSM as follows:
  - op 0 → LOAD
  - op 1 → CLEAR
  - op 2 → TOFF
  - op 3 → DONE with `err`.
- `start` outside IDLE is ignored.
- CLEAR (1 cycle): `rst_flag` = 1, `shift_en` = 0. Clears `found` and `first_row`, then moves to SCAN.
- SCAN (`num_qubit` cycles): `mux_shift_in` = 0, `shift_en` = 1, and the counter steps 0..num_qubit−1.
  - When `anticommute && !flag_anticommute`, latch `first_row` = counter and `found` = 1.
  - After the last row, the array has made a full revolution. If `found` = 1 go to UPDATE, otherwise go to DONE.
- UPDATE (`num_qubit` cycles): `shift_en` = 1. The mux select is combinational on the current head row:
  - counter == `first_row` → 1 (basis replaces the first anticommuting row)
  - else if `anticommute` → 2 (multiply by the captured row)
  - else → 0.
  - After the last row go to DONE.
- LOAD: `in_ready` = 1 and `mux_shift_in` = 3. `shift_en` = `in_valid`, and the counter advances per accepted row. After `num_qubit` accepted rows go to DONE. Stalls of any length are allowed.
- TOFF (`num_qubit` cycles): `mux_shift_in` = 4, `shift_en` = 1, then DONE.
- DONE (1 cycle): `done` = 1, then IDLE. The counter returns to 0.
- `busy` = 1 in every state except IDLE.
- Reset mid-operation: immediate return to the reset values. The array contents are left to their owner. No `done` pulse.

## Timing
- Cofactor latency from the `start` cycle to `done`:
  - 2·num_qubit + 2 cycles when an anticommuting row is found;
  - num_qubit + 2 cycles when none is found.
- Toffoli latency: num_qubit + 1 cycles.
- Load: num_qubit + 1 cycles plus stall cycles.
- `first_row` and `found` are stable from the cycle after capture.
- `mux_shift_in` and `shift_en` are valid in the same cycle the array samples them.
- A new `start` is accepted in the first IDLE cycle after `done`.

## Configuration
- `COFACTOR_TOFFOLI_EN` defined: op 2 runs TOFF as described above.
- Not defined: the TOFF state is omitted. op 2 is treated as illegal (DONE with `err` after 1 cycle), and `mux_shift_in` never takes the value 4.

## Test plan
- Reset, then load with num_qubit=3 and `in_valid` low for 2 cycles mid-load → exactly 3 shifts with mux 3, `done` 6 cycles after `start`, and `in_ready` low afterwards.
- Cofactor with head-row anticommute pattern 0,1,1 in SCAN → `found`=1, `first_row`=1; UPDATE mux sequence 0,1,2; `done` 8 cycles after `start`.
- Cofactor with pattern 0,0,0 → `found`=0, no UPDATE, `done` 5 cycles after `start`, `rst_flag` pulsed once.
- Toffoli op 2 with the macro defined → 3 cycles of mux 4, `done` at cycle 4. Without the macro → `done` and `err` at cycle 1, no shifts.
- `rst` driven low during UPDATE → all outputs 0 immediately. A new cofactor afterwards completes normally.
- `start` asserted while `busy`, and op 3 in IDLE → the busy `start` has no effect; op 3 produces `err`+`done` with no shift.

Source files
------------

// File: rtl/cofactor_shift_ctrl.sv
// ============================================================================
// Module   : cofactor_shift_ctrl
// Purpose  : Row-walk sequencer (load / cofactor / Toffoli) for the rotating
//            stabilizer row array. Optional Toffoli op: COFACTOR_TOFFOLI_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cofactor_shift_ctrl #(
   parameter int num_qubit = 3,
   parameter int CW        = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          anticommute,
   input  logic          flag_anticommute,
   output logic [2:0]    mux_shift_in,
   output logic          shift_en,
   output logic          rst_flag,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          found,
   output logic [CW-1:0] first_row
);

   localparam logic [CW-1:0] c_last_row   = CW'(num_qubit - 1);
   localparam logic [2:0]    c_mux_remain = 3'd0;
   localparam logic [2:0]    c_mux_basis  = 3'd1;
   localparam logic [2:0]    c_mux_mult   = 3'd2;
   localparam logic [2:0]    c_mux_ext    = 3'd3;
`ifdef COFACTOR_TOFFOLI_EN
   localparam logic [2:0]    c_mux_toff   = 3'd4;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_SCAN   = 3'd2,
      S_UPDATE = 3'd3,
      S_LOAD   = 3'd4,
      S_DONE   = 3'd5
`ifdef COFACTOR_TOFFOLI_EN
      ,
      S_TOFF   = 3'd6
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          found_q, found_d;
   logic [CW-1:0] first_row_q, first_row_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          rst_flag_q, rst_flag_d;
   logic          in_ready_q, in_ready_d;
   logic          last_row;

   assign last_row = (cnt_q == c_last_row);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      found_d      = found_q;
      first_row_d  = first_row_q;
      err_d        = 1'b0;
      mux_shift_in = c_mux_remain;
      shift_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               case (op)
                  2'd0: state_d = S_LOAD;
                  2'd1: begin
                     // Previous outcome is dropped as soon as a new cofactor starts.
                     state_d     = S_CLEAR;
                     found_d     = 1'b0;
                     first_row_d = '0;
                  end
`ifdef COFACTOR_TOFFOLI_EN
                  2'd2: state_d = S_TOFF;
                  default: begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end
`else
                  default: begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end
`endif
               endcase
            end
         end

         S_CLEAR: begin
            found_d     = 1'b0;
            first_row_d = '0;
            cnt_d       = '0;
            state_d     = S_SCAN;
         end

         S_SCAN: begin
            shift_en = 1'b1;
            if (anticommute && !flag_anticommute) begin
               first_row_d = cnt_q;
               found_d     = 1'b1;
            end
            if (last_row) begin
               cnt_d   = '0;
               state_d = found_d ? S_UPDATE : S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_UPDATE: begin
            shift_en = 1'b1;
            // The array is back at row 0, so the counter names the head row.
            if (cnt_q == first_row_q)
               mux_shift_in = c_mux_basis;
            else if (anticommute)
               mux_shift_in = c_mux_mult;
            else
               mux_shift_in = c_mux_remain;
            if (last_row) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_LOAD: begin
            mux_shift_in = c_mux_ext;
            shift_en     = in_valid;
            if (in_valid) begin
               if (last_row) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

`ifdef COFACTOR_TOFFOLI_EN
         S_TOFF: begin
            mux_shift_in = c_mux_toff;
            shift_en     = 1'b1;
            if (last_row) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif

         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they are registered.
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      rst_flag_d = (state_d == S_CLEAR);
      in_ready_d = (state_d == S_LOAD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         found_q     <= 1'b0;
         first_row_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         rst_flag_q  <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         found_q     <= found_d;
         first_row_q <= first_row_d;
         err_q       <= err_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         rst_flag_q  <= rst_flag_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign rst_flag  = rst_flag_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign found     = found_q;
   assign first_row = first_row_q;

endmodule

`default_nettype wire
